ext_adc_multi_sampler: RTL and testbench

Parametrised successor to the single-channel external-ADC sensor application. It sequences an external multiplexed ADC across up to NumChannels channels on a programmable period. Each channel gets its own threshold and its own compare mode (absolute or delta). The block keeps sticky per-channel event flags and raises a CPU interrupt pulse. It sits inside the reconfigurable logic, fed by parameter registers and the ADC/sensor pins.

---
 rtl/ext_adc_multi_sampler.sv | 177 +++++++++++++++++
 tb/tb_ext_adc_multi_sampler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_adc_multi_sampler.sv
// rtl/ext_adc_multi_sampler.sv - multi-channel external ADC sequencer with per-channel threshold/delta compare
module ext_adc_multi_sampler #(
    parameter int NumChannels = 4,
    parameter int ChSelWidth  = 2,
    parameter int AdcWidth    = 10,
    parameter int ValueWidth  = 16,
    parameter int TimerWidth  = 16
) (
    input  logic                              Clk_i,
    input  logic                              Reset_i,
    input  logic                              Enable_i,
    input  logic [NumChannels-1:0]            ChannelEnable_i,
    input  logic [NumChannels-1:0]            DeltaMode_i,
    input  logic [TimerWidth-1:0]             PeriodCounterPreset_i,
    input  logic [NumChannels*ValueWidth-1:0] Threshold_i,
    output logic                              SensorPower_o,
    input  logic                              SensorReady_i,
    output logic                              SensorStart_o,
    output logic [ChSelWidth-1:0]             AdcChannel_o,
    output logic                              AdcStart_o,
    input  logic                              AdcDone_i,
    input  logic [AdcWidth-1:0]               AdcValue_i,
    output logic [NumChannels*ValueWidth-1:0] SensorValue_o,
    output logic [NumChannels-1:0]            IntrChannels_o,
    input  logic                              IntrAck_i,
    output logic                              CpuIntr_o
);

    typedef enum logic [2:0] {
        S_DISABLED, S_IDLE, S_POWERUP, S_SELECT, S_CONVERT, S_COMPARE, S_DONE
    } state_t;

    state_t                            state_q, state_d;
    logic [TimerWidth-1:0]             timer_q, timer_d;
    logic [ChSelWidth-1:0]             ch_q, ch_d;
    logic [ValueWidth-1:0]             value_q, value_d;
    logic [NumChannels-1:0]            flags_q, flags_d;
    logic [NumChannels-1:0]            intr_q, intr_d;
    logic [NumChannels*ValueWidth-1:0] stored_q, stored_d;

    logic                  first_found, next_found, mode_cur, hit;
    logic [ChSelWidth-1:0] first_ch, next_ch;
    logic [ValueWidth-1:0] thr_cur, stored_cur, diff;

    // Channel search and per-channel operand selection for the current channel
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        next_found  = 1'b0;
        next_ch     = '0;
        thr_cur     = '0;
        stored_cur  = '0;
        mode_cur    = 1'b0;
        for (int n = 0; n < NumChannels; n++) begin
            if (!first_found && ChannelEnable_i[n]) begin
                first_found = 1'b1;
                first_ch    = ChSelWidth'(n);
            end
            if (!next_found && ChannelEnable_i[n] && (n > int'(ch_q))) begin
                next_found = 1'b1;
                next_ch    = ChSelWidth'(n);
            end
            if (ch_q == ChSelWidth'(n)) begin
                thr_cur    = Threshold_i[n*ValueWidth +: ValueWidth];
                stored_cur = stored_q[n*ValueWidth +: ValueWidth];
                mode_cur   = DeltaMode_i[n];
            end
        end
    end

    // Absolute difference taken in the larger-minus-smaller order so it never wraps
    assign diff = (value_q >= stored_cur) ? (value_q - stored_cur) : (stored_cur - value_q);
    assign hit  = mode_cur ? (diff > thr_cur) : (value_q > thr_cur);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        ch_d     = ch_q;
        value_d  = value_q;
        flags_d  = flags_q;
        stored_d = stored_q;
        intr_d   = intr_q;
        if (IntrAck_i) begin
            intr_d = '0;
        end
        case (state_q)
            S_DISABLED: begin
                if (Enable_i) begin
                    state_d = S_IDLE;
                    timer_d = PeriodCounterPreset_i;
                end
            end
            S_IDLE: begin
                if (!Enable_i) begin
                    state_d = S_DISABLED;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (ChannelEnable_i != '0) begin
                    state_d = S_POWERUP;
                end else begin
                    timer_d = PeriodCounterPreset_i;
                end
            end
            S_POWERUP: begin
                flags_d = '0;
                if (SensorReady_i) begin
                    ch_d    = first_ch;
                    state_d = first_found ? S_SELECT : S_DONE;
                end
            end
            S_SELECT: begin
                state_d = S_CONVERT;
            end
            S_CONVERT: begin
                if (AdcDone_i) begin
                    value_d                 = '0;
                    value_d[AdcWidth-1:0]   = AdcValue_i;
                    state_d                 = S_COMPARE;
                end
            end
            S_COMPARE: begin
                for (int n = 0; n < NumChannels; n++) begin
                    if (ch_q == ChSelWidth'(n)) begin
                        flags_d[n] = hit;
                        if (!mode_cur || hit) begin
                            stored_d[n*ValueWidth +: ValueWidth] = value_q;
                        end
                    end
                end
                if (next_found) begin
                    ch_d    = next_ch;
                    state_d = S_SELECT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                intr_d  = intr_d | flags_q;
                timer_d = PeriodCounterPreset_i;
                state_d = Enable_i ? S_IDLE : S_DISABLED;
            end
            default: begin
                state_d = S_DISABLED;
            end
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q  <= S_DISABLED;
            timer_q  <= '0;
            ch_q     <= '0;
            value_q  <= '0;
            flags_q  <= '0;
            stored_q <= '0;
            intr_q   <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            ch_q     <= ch_d;
            value_q  <= value_d;
            flags_q  <= flags_d;
            stored_q <= stored_d;
            intr_q   <= intr_d;
        end
    end

    assign SensorPower_o  = (state_q == S_POWERUP) || (state_q == S_SELECT) ||
                            (state_q == S_CONVERT) || (state_q == S_COMPARE);
    assign SensorStart_o  = (state_q == S_CONVERT);
    assign AdcStart_o     = (state_q == S_CONVERT);
    assign AdcChannel_o   = ch_q;
    assign SensorValue_o  = stored_q;
    assign IntrChannels_o = intr_q;
    assign CpuIntr_o      = (state_q == S_DONE) && (flags_q != '0);

endmodule

// File: tb/tb_ext_adc_multi_sampler.sv
// tb/tb_ext_adc_multi_sampler.sv - scoreboard bench for ext_adc_multi_sampler
module tb_ext_adc_multi_sampler;

    localparam int NC = 4;
    localparam int VW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           Enable_i;
    logic [NC-1:0]  ChannelEnable_i;
    logic [NC-1:0]  DeltaMode_i;
    logic [15:0]    PeriodCounterPreset_i;
    logic [NC*VW-1:0] Threshold_i;
    logic           SensorPower_o;
    logic           SensorReady_i;
    logic           SensorStart_o;
    logic [1:0]     AdcChannel_o;
    logic           AdcStart_o;
    logic           AdcDone_i;
    logic [9:0]     AdcValue_i;
    logic [NC*VW-1:0] SensorValue_o;
    logic [NC-1:0]  IntrChannels_o;
    logic           IntrAck_i;
    logic           CpuIntr_o;

    ext_adc_multi_sampler dut (
        .Clk_i(clk), .Reset_i(rst), .Enable_i(Enable_i),
        .ChannelEnable_i(ChannelEnable_i), .DeltaMode_i(DeltaMode_i),
        .PeriodCounterPreset_i(PeriodCounterPreset_i), .Threshold_i(Threshold_i),
        .SensorPower_o(SensorPower_o), .SensorReady_i(SensorReady_i),
        .SensorStart_o(SensorStart_o), .AdcChannel_o(AdcChannel_o),
        .AdcStart_o(AdcStart_o), .AdcDone_i(AdcDone_i), .AdcValue_i(AdcValue_i),
        .SensorValue_o(SensorValue_o), .IntrChannels_o(IntrChannels_o),
        .IntrAck_i(IntrAck_i), .CpuIntr_o(CpuIntr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NC-1:0]    intr;
        logic [NC*VW-1:0] sv;
        int               starts;
        logic [NC-1:0]    mask;
        int               cpu;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int sweeps_done = 0;
    int total_starts = 0;
    int last_gap = -1;
    logic [9:0] adc_tab [NC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [NC-1:0] intr, input logic [NC*VW-1:0] sv,
                        input int starts, input logic [NC-1:0] mask, input int cpu);
        exp_t e;
        e.intr = intr; e.sv = sv; e.starts = starts; e.mask = mask; e.cpu = cpu;
        exp_q.push_back(e);
    endtask

    // Sensor settle and ADC conversion model: done arrives on the third cycle of AdcStart_o
    int cnt = 0;
    int rdy = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            cnt = 0; rdy = 0; AdcDone_i = 1'b0; SensorReady_i = 1'b0;
        end else begin
            if (SensorPower_o) rdy++; else rdy = 0;
            SensorReady_i = (rdy >= 2);
            if (AdcDone_i) begin
                AdcDone_i = 1'b0; cnt = 0;
            end else if (AdcStart_o) begin
                cnt++;
                if (cnt == 3) begin
                    AdcDone_i  = 1'b1;
                    AdcValue_i = adc_tab[AdcChannel_o];
                end
            end
        end
    end

    // Monitor: a falling SensorPower_o marks DONE; results are compared one cycle later
    logic prev_pwr = 1'b0, prev_start = 1'b0, pending = 1'b0, counting = 1'b0;
    int starts = 0, cpu_cnt = 0, gap_cnt = 0;
    logic [NC-1:0] mask = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_pwr = 0; prev_start = 0; pending = 0; starts = 0; mask = '0; cpu_cnt = 0; counting = 0;
        end else begin
            if (pending) begin
                pending = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_sweep", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("intr_channels", 64'(IntrChannels_o), 64'(e.intr));
                    check("sensor_value", SensorValue_o, e.sv);
                    check("adc_handshakes", 64'(starts), 64'(e.starts));
                    check("channels_visited", 64'(mask), 64'(e.mask));
                    check("cpu_intr_pulses", 64'(cpu_cnt), 64'(e.cpu));
                end
                starts = 0; mask = '0; cpu_cnt = 0;
                sweeps_done++;
            end
            if (CpuIntr_o) cpu_cnt++;
            if (AdcStart_o && !prev_start) begin
                starts++; total_starts++; mask[AdcChannel_o] = 1'b1;
            end
            if (counting) begin
                if (SensorPower_o) begin last_gap = gap_cnt; counting = 0; end
                else gap_cnt++;
            end
            if (prev_pwr && !SensorPower_o) begin
                pending = 1'b1; counting = 1'b1; gap_cnt = 0;
            end
            prev_pwr = SensorPower_o; prev_start = AdcStart_o;
        end
    end

    task automatic run_sweeps(input int n);
        int target;
        target = sweeps_done + n;
        Enable_i = 1'b1;
        for (int i = 0; i < 4000 && sweeps_done < target; i++) @(negedge clk);
        if (sweeps_done < target) check("sweep_timeout", 64'(sweeps_done), 64'(target));
        Enable_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic seen;
        logic p;
        int t0;
        rst = 1'b1; Enable_i = 0; ChannelEnable_i = '0; DeltaMode_i = '0;
        PeriodCounterPreset_i = 16'd3; Threshold_i = '0; IntrAck_i = 0;
        AdcDone_i = 0; AdcValue_i = '0; SensorReady_i = 0;
        adc_tab[0] = 10'd100; adc_tab[1] = 10'd600; adc_tab[2] = 10'd512; adc_tab[3] = 10'd1023;
        do_reset();
        check("rst_power", 64'(SensorPower_o), 0);
        check("rst_adc_start", 64'(AdcStart_o), 0);
        check("rst_cpu_intr", 64'(CpuIntr_o), 0);
        check("rst_intr", 64'(IntrChannels_o), 0);
        check("rst_values", SensorValue_o, 0);

        // Absolute mode sweep of all four channels, T=512
        ChannelEnable_i = 4'b1111;
        Threshold_i = {16'd512, 16'd512, 16'd512, 16'd512};
        push(4'b1010, {16'd1023, 16'd512, 16'd600, 16'd100}, 4, 4'b1111, 1);
        run_sweeps(1);
        check("power_after_done", 64'(SensorPower_o), 0);

        // Sparse channel mask with preset 5, two back-to-back sweeps
        IntrAck_i = 1'b1; @(negedge clk); IntrAck_i = 1'b0; @(negedge clk);
        check("ack_clears", 64'(IntrChannels_o), 0);
        PeriodCounterPreset_i = 16'd5;
        ChannelEnable_i = 4'b0101;
        push(4'b0000, {16'd1023, 16'd512, 16'd600, 16'd100}, 2, 4'b0101, 0);
        push(4'b0000, {16'd1023, 16'd512, 16'd600, 16'd100}, 2, 4'b0101, 0);
        run_sweeps(2);
        check("idle_gap", 64'(last_gap), 6);

        // Delta mode on ch0, T=10: 100, 105, 120
        do_reset();
        PeriodCounterPreset_i = 16'd3;
        ChannelEnable_i = 4'b0001; DeltaMode_i = 4'b0001;
        Threshold_i = {16'd512, 16'd512, 16'd512, 16'd10};
        adc_tab[0] = 10'd100;
        push(4'b0001, {48'd0, 16'd100}, 1, 4'b0001, 1);
        run_sweeps(1);
        adc_tab[0] = 10'd105;
        push(4'b0001, {48'd0, 16'd100}, 1, 4'b0001, 0);
        run_sweeps(1);
        adc_tab[0] = 10'd120;
        push(4'b0001, {48'd0, 16'd120}, 1, 4'b0001, 1);
        run_sweeps(1);

        // Ack coinciding with a DONE that flags ch1
        DeltaMode_i = 4'b0000; ChannelEnable_i = 4'b0010;
        push(4'b0010, {16'd0, 16'd0, 16'd600, 16'd120}, 1, 4'b0010, 1);
        Enable_i = 1'b1;
        seen = 1'b0; p = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (p && !SensorPower_o) seen = 1'b1;
            p = SensorPower_o;
        end
        check("ack_done_found", 64'(seen), 1);
        IntrAck_i = 1'b1; Enable_i = 1'b0;
        @(negedge clk);
        IntrAck_i = 1'b0;
        repeat (3) @(negedge clk);

        // Enable dropped while ch1 converts: sweep still completes
        ChannelEnable_i = 4'b1111;
        Threshold_i = {16'd512, 16'd512, 16'd512, 16'd512};
        adc_tab[0] = 10'd100;
        push(4'b1010, {16'd1023, 16'd512, 16'd600, 16'd100}, 4, 4'b1111, 1);
        t0 = sweeps_done;
        Enable_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (AdcStart_o && AdcChannel_o == 2'd1) seen = 1'b1;
        end
        check("ch1_convert_found", 64'(seen), 1);
        Enable_i = 1'b0;
        for (int i = 0; i < 2000 && sweeps_done == t0; i++) @(negedge clk);
        check("sweep_after_disable", 64'(sweeps_done), 64'(t0 + 1));
        t0 = total_starts;
        repeat (60) @(negedge clk);
        check("no_start_when_disabled", 64'(total_starts), 64'(t0));

        // Reset in the middle of a conversion
        Enable_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (AdcStart_o && SensorPower_o) seen = 1'b1;
        end
        check("midsweep_found", 64'(seen), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_adc_start", 64'(AdcStart_o), 0);
        check("rst_mid_power", 64'(SensorPower_o), 0);
        check("rst_mid_intr", 64'(IntrChannels_o), 0);
        check("rst_mid_values", SensorValue_o, 0);
        @(negedge clk);
        rst = 1'b0;
        ChannelEnable_i = 4'b0000;
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (SensorPower_o) seen = 1'b1;
        end
        check("no_power_without_channels", 64'(seen), 0);
        Enable_i = 1'b0;

        check("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
